// File: rtl/sfq_tx_pkg.sv
// Shared types for the word-to-SFQ transmitter.
// Optional feature macro: SFQ_TX_PARITY_EN (adds a trailing odd-parity bit per word).
package sfq_tx_pkg;

  localparam int TX_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DATA,
    ST_SETUP,
    ST_CLOCK
`ifdef SFQ_TX_PARITY_EN
    , ST_PARITY
`endif
  } tx_state_t;

  // Odd-parity bit: 1 when the word holds an even number of ones.
  // Zero-extending a narrower word does not change its parity.
  function automatic logic odd_parity_bit(input logic [31:0] word);
    return ~^word;
  endfunction

endpackage

// File: rtl/sfq_word_tx_if.sv
// Parallel word input handshake for the SFQ transmitter.
interface sfq_word_tx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sfq_tx_fifo.sv
// Synchronous word FIFO; full/empty are registered so in_ready never
// depends combinationally on the same-cycle push.
module sfq_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + (AW+1)'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - (AW+1)'(1);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == L_DEPTH);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage array; contents need no reset since empty gates every read.
  always_ff @(posedge clkin) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/sfq_word_tx.sv
// Word-to-SFQ transmitter: buffers words and serialises them MSB-first as
// single-cycle data strobes, each followed GAP idle cycles later by a
// single-cycle clock strobe.
// Optional feature macro: SFQ_TX_PARITY_EN (trailing odd-parity bit per word).
//
// state  | meaning
// IDLE   | waiting for a queued word
// LOAD   | word in shift register, bit counter loaded
// DATA   | data strobe for the current MSB
// SETUP  | GAP quiet cycles before the clock strobe
// CLOCK  | clock strobe, shift to next bit or finish word
// PARITY | data strobe for the parity bit (parity build only)
module sfq_word_tx
  import sfq_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                clkin,
  input  logic                rst,
  sfq_word_tx_if.slave        s_in,
  output logic                data_pulse,
  output logic                clk_pulse,
  output logic                frame_pulse,
  output logic                busy,
  output logic [TX_CNT_W-1:0] tx_count
);

  localparam int BW = $clog2(WIDTH);

  tx_state_t            r_state;
  logic [WIDTH-1:0]     r_shift;
  logic [BW-1:0]        r_bit_cnt;
  logic [3:0]           r_gap_cnt;
  logic                 r_data_pulse;
  logic                 r_clk_pulse;
  logic                 r_frame_pulse;
  logic [TX_CNT_W-1:0]  r_tx_count;
`ifdef SFQ_TX_PARITY_EN
  logic                 r_par_bit;
  logic                 r_par_phase;
`endif

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_word_done;
  logic [WIDTH-1:0] w_fifo_data;

  assign w_push = s_in.in_valid && !w_full;

`ifdef SFQ_TX_PARITY_EN
  assign w_word_done = (r_bit_cnt == '0) && r_par_phase;
`else
  assign w_word_done = (r_bit_cnt == '0);
`endif

  // The head word is captured into the shift register on the pop itself,
  // so LOAD only has to arm the counter and the first strobe.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_CLOCK) && w_word_done));

  sfq_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clkin   (clkin),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (s_in.in_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Serialiser FSM; strobes are registered on entry to the state they belong to.
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_gap_cnt     <= '0;
      r_data_pulse  <= 1'b0;
      r_clk_pulse   <= 1'b0;
      r_frame_pulse <= 1'b0;
      r_tx_count    <= '0;
`ifdef SFQ_TX_PARITY_EN
      r_par_bit     <= 1'b0;
      r_par_phase   <= 1'b0;
`endif
    end else begin
      r_data_pulse  <= 1'b0;
      r_clk_pulse   <= 1'b0;
      r_frame_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift <= w_fifo_data;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_bit_cnt     <= BW'(WIDTH-1);
          r_data_pulse  <= r_shift[WIDTH-1];
          r_frame_pulse <= 1'b1;
`ifdef SFQ_TX_PARITY_EN
          r_par_bit     <= odd_parity_bit(32'(r_shift));
          r_par_phase   <= 1'b0;
`endif
          r_state       <= ST_DATA;
        end
        ST_DATA: begin
          r_gap_cnt <= 4'(GAP-1);
          r_state   <= ST_SETUP;
        end
`ifdef SFQ_TX_PARITY_EN
        ST_PARITY: begin
          r_gap_cnt <= 4'(GAP-1);
          r_state   <= ST_SETUP;
        end
`endif
        ST_SETUP: begin
          if (r_gap_cnt == '0) begin
            r_clk_pulse <= 1'b1;
            r_state     <= ST_CLOCK;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        ST_CLOCK: begin
          r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          if (r_bit_cnt != '0) begin
            r_bit_cnt    <= r_bit_cnt - BW'(1);
            r_data_pulse <= r_shift[WIDTH-2];
            r_state      <= ST_DATA;
          end
`ifdef SFQ_TX_PARITY_EN
          else if (!r_par_phase) begin
            r_par_phase  <= 1'b1;
            r_data_pulse <= r_par_bit;
            r_state      <= ST_PARITY;
          end
`endif
          else begin
            r_tx_count <= r_tx_count + TX_CNT_W'(1);
`ifdef SFQ_TX_PARITY_EN
            r_par_phase <= 1'b0;
`endif
            if (w_pop) begin
              r_shift <= w_fifo_data;
              r_state <= ST_LOAD;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_in.in_ready = !w_full;
  assign data_pulse    = r_data_pulse;
  assign clk_pulse     = r_clk_pulse;
  assign frame_pulse   = r_frame_pulse;
  assign busy          = (r_state != ST_IDLE) || !w_empty;
  assign tx_count      = r_tx_count;

endmodule

// File: tb/tb_sfq_word_tx.sv
// Self-checking bench for sfq_word_tx: a cycle-indexed pulse schedule is
// computed per accepted word and compared against the DUT every cycle.
module tb_sfq_word_tx;

  localparam int W   = 8;
  localparam int DEP = 4;
  localparam int G   = 1;
  localparam int N   = 4096;
`ifdef SFQ_TX_PARITY_EN
  localparam int NB  = W + 1;
`else
  localparam int NB  = W;
`endif

  logic clkin = 1'b0;
  logic rst   = 1'b1;
  always #5 clkin = ~clkin;

  sfq_word_tx_if #(.WIDTH(W)) in_if ();
  sfq_word_tx_if #(.WIDTH(W)) in_if3 ();

  logic        d1_data, d1_clk, d1_frame, d1_busy;
  logic [15:0] d1_txc;
  logic        d3_data, d3_clk, d3_frame, d3_busy;
  logic [15:0] d3_txc;

  sfq_word_tx #(.WIDTH(W), .DEPTH(DEP), .GAP(G)) dut (
    .clkin       (clkin),
    .rst         (rst),
    .s_in        (in_if),
    .data_pulse  (d1_data),
    .clk_pulse   (d1_clk),
    .frame_pulse (d1_frame),
    .busy        (d1_busy),
    .tx_count    (d1_txc)
  );

  sfq_word_tx #(.WIDTH(W), .DEPTH(DEP), .GAP(3)) dut3 (
    .clkin       (clkin),
    .rst         (rst),
    .s_in        (in_if3),
    .data_pulse  (d3_data),
    .clk_pulse   (d3_clk),
    .frame_pulse (d3_frame),
    .busy        (d3_busy),
    .tx_count    (d3_txc)
  );

  // Reference schedule, indexed by clock edge since the last reset.
  bit          exp_data  [N];
  bit          exp_clk   [N];
  bit          exp_frame [N];
  bit          busy_st   [N];
  int          push_at   [N];
  int          pop_at    [N];
  int          inc_at    [N];
  int          cyc, occ, next_free, last_load;
  logic [15:0] txc;
  logic        model_ready;
  int          vectors = 0;
  int          fails   = 0;
  int          tally_data, tally_clk;
  int          q3c[$];
  int          q3d[$];
  logic        pushed;

  task automatic cmp_bit(input string tag, input logic got, input logic exp, input int n);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, n, got, exp);
    end
  endtask

  task automatic cmp_int(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Word accepted at edge p: it starts loading one edge later, or as soon
  // as the previous word finishes; each bit occupies G+2 cycles.
  task automatic schedule(input int p, input logic [W-1:0] d);
    int l, dc, done;
    logic b;
    l = (p + 1 > next_free) ? p + 1 : next_free;
    last_load = l;
    push_at[p]++;
    pop_at[l]++;
    for (int k = 0; k < NB; k++) begin
      b  = (k < W) ? d[W-1-k] : ~^d;
      dc = l + 1 + k * (G + 2);
      exp_data[dc]        = b;
      exp_clk[dc + G + 1] = 1'b1;
      if (k == 0) exp_frame[dc] = 1'b1;
    end
    done = l + 1 + NB * (G + 2);
    for (int c = l; c < done; c++) busy_st[c] = 1'b1;
    inc_at[done]++;
    next_free = done;
  endtask

  task automatic check(input int n);
    logic e_busy, e_ready;
    occ += push_at[n] - pop_at[n];
    txc += 16'(inc_at[n]);
    e_busy  = busy_st[n] || (occ > 0);
    e_ready = (occ < DEP);
    cmp_bit("data_pulse",  d1_data,  exp_data[n],  n);
    cmp_bit("clk_pulse",   d1_clk,   exp_clk[n],   n);
    cmp_bit("frame_pulse", d1_frame, exp_frame[n], n);
    cmp_bit("busy",        d1_busy,  e_busy,       n);
    cmp_bit("in_ready",    in_if.in_ready, e_ready, n);
    cmp_int("tx_count",    int'(d1_txc), int'(txc));
    model_ready = e_ready;
    if (d1_data) tally_data++;
    if (d1_clk)  tally_clk++;
    if (d3_clk)  q3c.push_back(n);
    if (d3_data) q3d.push_back(n);
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, output logic acc);
    in_if.in_valid = v;
    in_if.in_data  = d;
    acc = v && model_ready;
    @(posedge clkin);
    cyc++;
    if (acc) schedule(cyc, d);
    #1;
    check(cyc);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, a);
  endtask

  task automatic drain();
    int k;
    k = next_free - cyc + 3;
    if (k < 3) k = 3;
    idle(k);
  endtask

  task automatic do_reset();
    in_if.in_valid  = 1'b0;
    in_if3.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clkin);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_data[i] = 0; exp_clk[i] = 0; exp_frame[i] = 0; busy_st[i] = 0;
      push_at[i] = 0;  pop_at[i] = 0;  inc_at[i] = 0;
    end
    cyc = 0; occ = 0; next_free = 0; last_load = 0;
    txc = '0; model_ready = 1'b1;
    tally_data = 0; tally_clk = 0;
    check(0);
  endtask

  initial begin : main
    int l81, target, guard, gap_meas, spacing;
    logic [W-1:0] burst [6];
    in_if.in_valid  = 1'b0;
    in_if.in_data   = '0;
    in_if3.in_valid = 1'b0;
    in_if3.in_data  = '0;

    // Single word 8'hA5: 4 data strobes, 8 clock strobes, count 1.
    do_reset();
    step(1'b1, 8'hA5, pushed);
    idle(30);
    cmp_int("a5_data_strobes", tally_data, 4 + ((NB > W) ? 1 : 0));
    cmp_int("a5_clk_strobes",  tally_clk, NB);
    cmp_int("a5_tx_count",     int'(d1_txc), 1);

    // Back-to-back 8'hFF then 8'h00.
    do_reset();
    step(1'b1, 8'hFF, pushed);
    step(1'b1, 8'h00, pushed);
    drain();
    cmp_int("b2b_data_strobes", tally_data, 8 + ((NB > W) ? 2 : 0));
    cmp_int("b2b_tx_count",     int'(d1_txc), 2);

    // Six words with in_valid held: backpressure must not lose or repeat any.
    do_reset();
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h3C;
    burst[3] = 8'h80; burst[4] = 8'h01; burst[5] = 8'hE7;
    for (int i = 0; i < 6; i++) begin
      guard = 0;
      pushed = 1'b0;
      while (!pushed && guard < 200) begin
        step(1'b1, burst[i], pushed);
        guard++;
      end
      cmp_int("burst_accept", int'(pushed), 1);
    end
    drain();
    cmp_int("burst_tx_count", int'(d1_txc), 6);

    // Reset during bit 3 of 8'h81 with two words queued behind it.
    do_reset();
    step(1'b1, 8'h81, pushed);
    l81 = last_load;
    step(1'b1, 8'h5A, pushed);
    step(1'b1, 8'hC3, pushed);
    target = l81 + 1 + 3 * (G + 2);
    while (cyc < target) idle(1);
    do_reset();
    idle(60);
    cmp_int("rst_mid_pulses", tally_data + tally_clk, 0);
    cmp_int("rst_mid_tx_count", int'(d1_txc), 0);

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 2) != 0), W'($urandom), pushed);
    drain();

    // GAP=3 instance: bit time 5, data strobe 4 edges before its clock strobe.
    do_reset();
    cmp_int("gap3_ready", int'(in_if3.in_ready), 1);
    q3c.delete();
    q3d.delete();
    in_if3.in_valid = 1'b1;
    in_if3.in_data  = 8'h01;
    step(1'b0, '0, pushed);
    in_if3.in_valid = 1'b0;
    idle(60);
    cmp_int("gap3_clk_strobes",  q3c.size(), NB);
    cmp_int("gap3_tx_count",     int'(d3_txc), 1);
    if (q3c.size() >= 8 && q3d.size() >= 1) begin
      gap_meas = q3c[7] - q3d[0];
      spacing  = q3c[1] - q3c[0];
    end else begin
      gap_meas = -1;
      spacing  = -1;
    end
    cmp_int("gap3_data_to_clk", gap_meas, 4);
    cmp_int("gap3_bit_time",    spacing, 5);

`ifdef SFQ_TX_PARITY_EN
    // Parity: 8'h03 sends parity 1, 8'h07 sends parity 0.
    do_reset();
    step(1'b1, 8'h03, pushed);
    drain();
    cmp_int("par03_clk_strobes",  tally_clk, 9);
    cmp_int("par03_data_strobes", tally_data, 3);
    do_reset();
    step(1'b1, 8'h07, pushed);
    drain();
    cmp_int("par07_data_strobes", tally_data, 3);

    // Counter wrap from 0xFFFF.
    do_reset();
    force dut.r_tx_count = 16'hFFFF;
    @(negedge clkin);
    release dut.r_tx_count;
    #1;
    txc = 16'hFFFF;
    step(1'b1, 8'h96, pushed);
    drain();
    cmp_int("wrap_tx_count", int'(d1_txc), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
